mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes one IDLE sample edge plus one ACCESS cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_done,
    output logic              b_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e state;
    logic   last_b;
    logic   pick_b;

    // B wins if it is the only requester, or on a tie when A was served last.
    assign pick_b = b_req && (!a_req || !last_b);

    // The memory-side outputs double as the latched command registers:
    // they hold the winner's command during ACCESS and are zero in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            last_b         <= 1'b1;
            a_gnt          <= 1'b0;
            b_gnt          <= 1'b0;
            a_done         <= 1'b0;
            b_done         <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    if (a_req || b_req) begin
                        state          <= StAccess;
                        last_b         <= pick_b;
                        a_gnt          <= !pick_b;
                        b_gnt          <= pick_b;
                        mem_write      <= pick_b ? b_we : a_we;
                        mem_address    <= pick_b ? b_addr : a_addr;
                        mem_write_data <= pick_b ? b_wdata : a_wdata;
                    end
                end
                StAccess: begin
                    state          <= StIdle;
                    a_gnt          <= 1'b0;
                    b_gnt          <= 1'b0;
                    a_done         <= a_gnt;
                    b_done         <= b_gnt;
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    mem_write      <= 1'b0;
                    if (!mem_write) begin
                        if (b_gnt) begin
                            b_rdata <= mem_read_data;
                        end else begin
                            a_rdata <= mem_read_data;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
